// File: rtl/mem_map_decoder.sv
// mem_map_decoder
//   Address decoder and read-data interconnect for the 65C02 system bus.
//   It decodes NUM_REGIONS address windows, each with its own base,
//   inclusive last address and wait-state count. It stretches slow
//   accesses through cpu_rdy and registers the read-mux select so that it
//   lines up with synchronous device outputs. Unmapped reads return
//   DEFAULT_DATA, which is a NOP opcode.
//
// Ports
//   clk        in   system clock (phi2)
//   resb       in   asynchronous active-low reset
//   cpu_addr   in   CPU address bus
//   cpu_we     in   CPU write enable
//   cpu_rdy    out  CPU ready, low stalls the CPU (forced high in reset)
//   cpu_di     out  read data to the CPU
//   dev_sel    out  one-hot combinational chip enable per region
//   dev_we     out  per-region write strobe, completing cycle only
//   dev_rdata  in   packed device read data, region i at [i*DATA_W +: DATA_W]
//   addr_q     out  registered external address pads
//   unmapped   out  one-cycle flag for a completed unmapped access
//
// State table
//   ST_RUN  | idle or zero-wait access; loads cnt when a wait region is hit
//   ST_WAIT | stretching an access; cpu_rdy rises when cnt reaches zero
module mem_map_decoder #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {16'h9000, 16'hC000, 16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LAST =
    {16'h9FFF, 16'hFFFF, 16'h800F, 16'h7FFF},
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT =
    {4'd3, 4'd0, 4'd2, 4'd0},
  parameter logic [DATA_W-1:0] DEFAULT_DATA = 8'hEA
) (
  input  logic                          clk,
  input  logic                          resb,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic                          cpu_we,
  output logic                          cpu_rdy,
  output logic [DATA_W-1:0]             cpu_di,
  output logic [NUM_REGIONS-1:0]        dev_sel,
  output logic [NUM_REGIONS-1:0]        dev_we,
  input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata,
  output logic [ADDR_W-1:0]             addr_q,
  output logic                          unmapped
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             rd;
  } sel_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  sel_t             sel_q, sel_d;
  logic [ADDR_W-1:0] addr_d;
  logic             unmapped_q, unmapped_d;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [3:0]       wait_w;
  logic             rdy_fsm;

  // Scan from the top index down so the lowest matching region overrides.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (cpu_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
          cpu_addr <= REGION_LAST[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    dev_sel = '0;
    if (hit) dev_sel[hit_idx] = 1'b1;
  end

  assign wait_w = hit ? REGION_WAIT[int'(hit_idx)*4 +: 4] : 4'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_fsm = 1'b1;
    case (state_q)
      ST_RUN: begin
        rdy_fsm = (wait_w == 4'd0);
        if (wait_w != 4'd0) begin
          state_d = ST_WAIT;
          cnt_d   = wait_w - 4'd1;
        end
      end
      ST_WAIT: begin
        rdy_fsm = (cnt_q == 4'd0);
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The CPU must never stall while reset is held. Gating the write strobe
  // with resb keeps a forced-ready reset cycle from looking like a write.
  assign cpu_rdy = rdy_fsm | ~resb;
  assign dev_we  = dev_sel & {NUM_REGIONS{cpu_we & rdy_fsm & resb}};

  assign sel_d      = '{idx: hit_idx, valid: hit, rd: ~cpu_we};
  assign addr_d     = rdy_fsm ? cpu_addr : addr_q;
  assign unmapped_d = ~hit & rdy_fsm;

  // Select is one cycle behind the address to match synchronous devices.
  assign cpu_di = (sel_q.valid && sel_q.rd)
                  ? dev_rdata[int'(sel_q.idx)*DATA_W +: DATA_W]
                  : DEFAULT_DATA;

  assign unmapped = unmapped_q;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      sel_q      <= '0;
      addr_q     <= '0;
      unmapped_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      unmapped_q <= unmapped_d;
    end
  end

endmodule

// File: tb/tb_mem_map_decoder.sv
module tb_mem_map_decoder;

  logic        clk = 1'b0;
  logic        resb = 1'b0;
  logic [15:0] cpu_addr = 16'h9000;
  logic        cpu_we = 1'b0;
  logic [31:0] dev_rdata = {8'h77, 8'hC3, 8'h11, 8'h5A};

  logic        cpu_rdy;
  logic [7:0]  cpu_di;
  logic [3:0]  dev_sel, dev_we;
  logic [15:0] addr_q;
  logic        unmapped;

  logic        o_rdy;
  logic [7:0]  o_di;
  logic [3:0]  o_sel, o_we;
  logic [15:0] o_addr_q;
  logic        o_unm;

  always #5 clk = ~clk;

  mem_map_decoder dut (
    .clk(clk), .resb(resb), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy), .cpu_di(cpu_di), .dev_sel(dev_sel), .dev_we(dev_we),
    .dev_rdata(dev_rdata), .addr_q(addr_q), .unmapped(unmapped)
  );

  // Region 3 moved down to overlap region 1.
  mem_map_decoder #(
    .REGION_BASE({16'h8000, 16'hC000, 16'h8000, 16'h0000})
  ) dut_ovl (
    .clk(clk), .resb(resb), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_rdy(o_rdy), .cpu_di(o_di), .dev_sel(o_sel), .dev_we(o_we),
    .dev_rdata(dev_rdata), .addr_q(o_addr_q), .unmapped(o_unm)
  );

  typedef struct {
    string       nm;
    logic        rdy;
    logic [3:0]  sel;
    logic [3:0]  we;
    logic [7:0]  di;
    logic [15:0] aq;
    logic        unm;
    logic        ck_ovl;
    logic [3:0]  ovl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string nm, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: every cycle that has an expected record is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "cpu_rdy",  16'(cpu_rdy),  16'(e.rdy));
      chk(e.nm, "dev_sel",  16'(dev_sel),  16'(e.sel));
      chk(e.nm, "dev_we",   16'(dev_we),   16'(e.we));
      chk(e.nm, "cpu_di",   16'(cpu_di),   16'(e.di));
      chk(e.nm, "addr_q",   addr_q,        e.aq);
      chk(e.nm, "unmapped", 16'(unmapped), 16'(e.unm));
      if (e.ck_ovl) chk(e.nm, "ovl_sel", 16'(o_sel), 16'(e.ovl));
    end
  end

  task automatic step(input string nm, input logic rb, input logic [15:0] a,
                      input logic w, input logic e_rdy, input logic [3:0] e_sel,
                      input logic [3:0] e_we, input logic [7:0] e_di,
                      input logic [15:0] e_aq, input logic e_unm,
                      input logic ck_ovl = 1'b0, input logic [3:0] e_ovl = 4'd0);
    exp_t e;
    @(posedge clk);
    #1;
    resb     = rb;
    cpu_addr = a;
    cpu_we   = w;
    e = '{nm: nm, rdy: e_rdy, sel: e_sel, we: e_we, di: e_di, aq: e_aq,
          unm: e_unm, ck_ovl: ck_ovl, ovl: e_ovl};
    exp_q.push_back(e);
  endtask

  initial begin
    //   name         resb addr      we rdy sel      we       di     addr_q    unm
    // Reset, then a 3-wait read of region 3
    step("rst0",      0, 16'h9000, 0, 1, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("rst1",      0, 16'h9000, 0, 1, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("rel_run",   1, 16'h9000, 0, 0, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("rel_w2",    1, 16'h9000, 0, 0, 4'b1000, 4'b0000, 8'h77, 16'h0000, 0);
    step("rel_w1",    1, 16'h9000, 0, 0, 4'b1000, 4'b0000, 8'h77, 16'h0000, 0);
    step("rel_done",  1, 16'h9000, 0, 1, 4'b1000, 4'b0000, 8'h77, 16'h0000, 0);
    // RAM read, then ACIA write (2 waits)
    step("ram_rd",    1, 16'h1234, 0, 1, 4'b0001, 4'b0000, 8'h77, 16'h9000, 0);
    step("acia_wr0",  1, 16'h8003, 1, 0, 4'b0010, 4'b0000, 8'h5A, 16'h1234, 0);
    step("acia_wr1",  1, 16'h8003, 1, 0, 4'b0010, 4'b0000, 8'hEA, 16'h1234, 0);
    step("acia_wrD",  1, 16'h8003, 1, 1, 4'b0010, 4'b0010, 8'hEA, 16'h1234, 0);
    // Unmapped read
    step("unm_rd",    1, 16'hA000, 0, 1, 4'b0000, 4'b0000, 8'hEA, 16'h8003, 0);
    step("unm_after", 1, 16'h1234, 0, 1, 4'b0001, 4'b0000, 8'hEA, 16'hA000, 1);
    // Edge sweep: region 1 LAST, LAST+1, gap, region 2 BASE and LAST
    step("e800F_0",   1, 16'h800F, 0, 0, 4'b0010, 4'b0000, 8'h5A, 16'h1234, 0);
    step("e800F_1",   1, 16'h800F, 0, 0, 4'b0010, 4'b0000, 8'h11, 16'h1234, 0);
    step("e800F_D",   1, 16'h800F, 0, 1, 4'b0010, 4'b0000, 8'h11, 16'h1234, 0);
    step("e8010",     1, 16'h8010, 0, 1, 4'b0000, 4'b0000, 8'h11, 16'h800F, 0);
    step("eBFFF",     1, 16'hBFFF, 0, 1, 4'b0000, 4'b0000, 8'hEA, 16'h8010, 1);
    step("eC000",     1, 16'hC000, 0, 1, 4'b0100, 4'b0000, 8'hEA, 16'hBFFF, 1);
    step("eFFFF",     1, 16'hFFFF, 0, 1, 4'b0100, 4'b0000, 8'hC3, 16'hC000, 0);
    // Overlap: the second decoder must still pick region 1 for 8005
    step("ovl_0",     1, 16'h8005, 0, 0, 4'b0010, 4'b0000, 8'hC3, 16'hFFFF, 0, 1, 4'b0010);
    step("ovl_1",     1, 16'h8005, 0, 0, 4'b0010, 4'b0000, 8'h11, 16'hFFFF, 0);
    step("ovl_D",     1, 16'h8005, 0, 1, 4'b0010, 4'b0000, 8'h11, 16'hFFFF, 0);
    // Back-to-back wait write to region 3, reset on the 2nd stall cycle
    step("abrt_run",  1, 16'h9000, 1, 0, 4'b1000, 4'b0000, 8'h11, 16'h8005, 0);
    step("abrt_rst",  0, 16'h9000, 1, 1, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("abrt_hold", 0, 16'h9000, 1, 1, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("rstrt_0",   1, 16'h9000, 1, 0, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("rstrt_1",   1, 16'h9000, 1, 0, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("rstrt_2",   1, 16'h9000, 1, 0, 4'b1000, 4'b0000, 8'hEA, 16'h0000, 0);
    step("rstrt_D",   1, 16'h9000, 1, 1, 4'b1000, 4'b1000, 8'hEA, 16'h0000, 0);
    step("post_rd0",  1, 16'h1234, 0, 1, 4'b0001, 4'b0000, 8'hEA, 16'h9000, 0);
    step("post_rd1",  1, 16'h1234, 0, 1, 4'b0001, 4'b0000, 8'h5A, 16'h1234, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || !stim_done) begin
      n_bad++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
